// File: rtl/dht_multi_sampler_if.sv
// Result port of the DHT multi-channel sampler: one measurement per valid/ready transfer.
interface dht_multi_sampler_if;
  logic        valid;
  logic        ready;
  logic [2:0]  ch;
  logic [31:0] data;
  logic        err;
  logic [3:0]  tries;

  modport master (output valid, ch, data, err, tries, input ready);
  modport slave  (input valid, ch, data, err, tries, output ready);
endinterface

// File: rtl/dht_multi_sampler.sv
// Sequences N_CH DHT11 cores: power-up hold, periodic rounds, per-channel reset/start,
// completion/timeout detection with bounded retry, and one result per channel on a valid/ready port.
module dht_multi_sampler #(
  parameter int N_CH        = 2,
  parameter int POWERUP_CYC = 100000000,
  parameter int PERIOD_CYC  = 200000000,
  parameter int RST_CYC     = 1000,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic [N_CH-1:0]      core_en,
  output logic [N_CH-1:0]      core_rst,
  input  logic [N_CH-1:0]      core_wait,
  input  logic [N_CH-1:0]      core_error,
  input  logic [N_CH-1:0]      core_crc_ok,
  input  logic [32*N_CH-1:0]   core_data,
  dht_multi_sampler_if.master  res,
  output logic                 started,
  output logic                 busy
);

  typedef enum logic [2:0] {S_POWERUP, S_IDLE, S_CRST, S_RUN, S_EMIT} state_t;

  localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYC - 1);
  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYC - 1);
  localparam logic [31:0] RST_LAST     = 32'(RST_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);
  localparam logic [2:0]  CH_LAST      = 3'(N_CH - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  ch_q, ch_d;
  logic [3:0]  tries_q, tries_d;
  logic        seen_q, seen_d;
  logic        started_q, started_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // Zero-padded to the 8-channel maximum so a 3-bit channel index always selects in range.
  logic [7:0]   wait_pad, error_pad, crc_pad, ch_onehot;
  logic [255:0] data_pad;
  logic         sel_wait, sel_fail, timeout, done;
  logic [31:0]  sel_data;

  assign wait_pad  = 8'(core_wait);
  assign error_pad = 8'(core_error);
  assign crc_pad   = 8'(core_crc_ok);
  assign data_pad  = 256'(core_data);
  assign ch_onehot = 8'd1 << ch_q;

  assign sel_wait = wait_pad[ch_q];
  assign sel_fail = error_pad[ch_q] | ~crc_pad[ch_q];
  assign sel_data = data_pad[{ch_q, 5'b0} +: 32];
  assign timeout  = (cnt_q == TIMEOUT_LAST);
  assign done     = seen_q & ~sel_wait;

  // NOTE: every flop is updated with <= so all state advances together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_POWERUP;
      cnt_q     <= '0;
      ch_q      <= '0;
      tries_q   <= '0;
      seen_q    <= 1'b0;
      started_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      tries_q   <= tries_d;
      seen_q    <= seen_d;
      started_q <= started_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // NOTE: all next-state values default to the current ones first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    tries_d   = tries_q;
    seen_d    = seen_q;
    started_d = started_q;
    data_d    = data_q;
    err_d     = err_q;
    unique case (state_q)
      S_POWERUP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == POWERUP_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          started_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          state_d = S_CRST;
          cnt_d   = '0;
          ch_d    = '0;
          tries_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_CRST: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (sel_wait) seen_d = 1'b1;
        if (timeout || done) begin
          // Timeout wins over a simultaneous completion and reports no data.
          data_d = timeout ? 32'd0 : sel_data;
          err_d  = timeout | sel_fail;
          cnt_d  = '0;
          if ((timeout || sel_fail) && (tries_q < RETRY_MAX)) begin
            tries_d = tries_q + 4'd1;
            state_d = S_CRST;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (res.ready) begin
          cnt_d = '0;
          if ((ch_q < CH_LAST) && enable) begin
            ch_d    = ch_q + 3'd1;
            tries_d = '0;
            state_d = S_CRST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  always_comb begin
    core_en  = '0;
    core_rst = '0;
    if (state_q == S_POWERUP) core_rst = '1;
    if (state_q == S_CRST)    core_rst = ch_onehot[N_CH-1:0];
    if (state_q == S_RUN)     core_en  = ch_onehot[N_CH-1:0];
  end

  assign res.valid = (state_q == S_EMIT);
  assign res.ch    = ch_q;
  assign res.data  = data_q;
  assign res.err   = err_q;
  assign res.tries = tries_q;
  assign started   = started_q;
  assign busy      = (state_q != S_POWERUP) && (state_q != S_IDLE);

endmodule

// File: doc/dht_multi_sampler.md
Name: dht_multi_sampler

Overview:
- Parametrised successor to the single-sensor start/run mux that drives the DHT11 core from the top level.
- One controller sequences N_CH DHT11 core instances: power-up hold, periodic sampling rounds, per-channel core reset, start, completion detection, timeout, bounded retry.
- Results are delivered one channel at a time on a valid/ready result port, for the SPI display/transmit path.

Parameters:
- N_CH, 2, number of DHT11 core instances (1..8)
- POWERUP_CYC, 100000000, cycles all cores are held in reset after RST_N release (1 s at 100 MHz)
- PERIOD_CYC, 200000000, idle cycles between sampling rounds
- RST_CYC, 1000, cycles CORE_RST[ch] is asserted before each attempt
- TIMEOUT_CYC, 5000000, maximum cycles from attempt start to completion
- MAX_RETRY, 2, retries after a failed attempt (0..15)

Ports:
- CLK  in  1  main clock, 100 MHz
- RST_N  in  1  asynchronous active-low reset
- ENABLE  in  1  sampling enable
- CORE_EN  out  N_CH  per-core enable, at most one bit high
- CORE_RST  out  N_CH  per-core reset, active high
- CORE_WAIT  in  N_CH  per-core busy
- CORE_ERROR  in  N_CH  per-core error flag
- CORE_CRC_OK  in  N_CH  per-core checksum match
- CORE_DATA  in  32*N_CH  channel ch at bits [32*ch+31:32*ch] = {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT}
- RES_VALID  out  1  result valid
- RES_READY  in  1  result accepted
- RES_CH  out  3  channel index
- RES_DATA  out  32  captured measurement
- RES_ERR  out  1  final attempt failed or timed out
- RES_TRIES  out  4  retries consumed
- STARTED  out  1  power-up hold complete
- BUSY  out  1  state is neither POWERUP nor IDLE

Behaviour:
- Reset (RST_N low, asynchronous): state POWERUP, CORE_RST all ones, CORE_EN 0, RES_VALID 0, RES_CH/RES_DATA/RES_ERR/RES_TRIES 0, STARTED 0, BUSY 0, all counters 0. Applies immediately, including mid-attempt.
- POWERUP:
  - CORE_RST all ones for POWERUP_CYC cycles.
  - Then STARTED=1 (held until reset), CORE_RST all zero, go to IDLE.
- IDLE:
  - Period counter increments while ENABLE=1; it clears whenever ENABLE=0.
  - When the counter reaches PERIOD_CYC-1: ch=0, tries=0, go to CRST.
- CRST: CORE_RST[ch]=1 for RST_CYC cycles, then START.
- START/BUSY:
  - CORE_EN[ch]=1 and the attempt timer clears on entry.
  - Completion is CORE_WAIT[ch]==0 in a cycle after CORE_WAIT[ch]==1 has been seen during this attempt.
  - Timeout is the attempt timer reaching TIMEOUT_CYC-1 without completion; timeout takes priority if both occur in the same cycle.
- On the completion cycle:
  - fail = CORE_ERROR[ch] | ~CORE_CRC_OK[ch].
  - CORE_DATA slice is captured into the result register.
  - CORE_EN[ch] is 0 from the next cycle.
- Retry decision, taken on completion or timeout:
  - If (fail or timeout) and tries<MAX_RETRY: tries++, return to CRST.
  - Otherwise go to EMIT.
  - Timeout captures data 0.
- EMIT:
  - RES_VALID rises the cycle after completion or timeout.
  - RES_CH=ch, RES_DATA=captured value, RES_ERR=fail|timeout, RES_TRIES=tries.
  - All RES_* outputs stay stable while RES_READY=0.
  - Handshake cycle (RES_VALID & RES_READY): RES_VALID falls next cycle. If ch<N_CH-1 and ENABLE=1: ch++, tries=0, go to CRST. Otherwise go to IDLE with the period counter cleared.
- ENABLE falling mid-round: the current channel completes and emits; remaining channels are skipped.
- CORE_WAIT/ERROR/CRC_OK of non-selected channels are ignored.
- CORE_EN and CORE_RST are never both high for the same channel.

Test Plan:
- Power-up, N_CH=2, POWERUP_CYC=10: release RST_N -> CORE_RST=2'b11 and STARTED=0 for exactly 10 cycles, then CORE_RST=2'b00 and STARTED=1.
- Normal round, PERIOD_CYC=20, RST_CYC=4, RES_READY=1:
  - Stimulus: core models pulse WAIT for 30 cycles; data ch0=0x2D001A05, ch1=0x30001900.
  - Required: results ch0 then ch1, RES_ERR=0, RES_TRIES=0.
  - Required: RES_VALID rises 1 cycle after each WAIT fall.
- Retry success: ch0 ERROR=1 on first attempt, 0 on second -> CORE_RST[0] pulses twice, one result ch0 with RES_TRIES=1, RES_ERR=0. A CRC_OK=0 first attempt produces the same result.
- Timeout exhaustion, MAX_RETRY=2, TIMEOUT_CYC=50: ch1 WAIT never rises -> 3 attempts of 50 cycles each, result ch1 with RES_ERR=1, RES_TRIES=2, RES_DATA=0.
- Backpressure: RES_READY low for 20 cycles during EMIT -> RES_VALID and all RES_* stable, CORE_EN stays 0; ch1 CRST begins the cycle after the handshake.
- Reset mid-attempt: RST_N low while CORE_EN[0]=1 -> same cycle CORE_EN=0, CORE_RST all ones, RES_VALID=0, STARTED=0; on release, the full POWERUP sequence repeats.
